// File: rtl/histogram_bellek_pkg.sv
// Shared constants and state encoding for the histogram SRAM responder.
package histogram_bellek_pkg;

  localparam int C_PIXEL_BIT = 8;
  localparam int C_DATA_BIT  = 17;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  typedef enum logic {
    TEMIZLE = 1'b0,
    BOSTA   = 1'b1
  } durum_t;

endpackage

// File: rtl/histogram_bellek_dizi.sv
// Raw simple dual-port array: synchronous write, registered synchronous read.
module histogram_bellek_dizi #(
  parameter int PIXEL_BIT = 8,
  parameter int DATA_BIT  = 17
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 we_i,
  input  logic [PIXEL_BIT-1:0] waddr_i,
  input  logic [DATA_BIT-1:0]  wdata_i,
  input  logic                 re_i,
  input  logic [PIXEL_BIT-1:0] raddr_i,
  output logic [DATA_BIT-1:0]  rdata_o
);

  logic [DATA_BIT-1:0] r_mem [2**PIXEL_BIT];
  logic [DATA_BIT-1:0] r_rdata;

  // NOTE: the array has no reset so it maps onto SRAM; the clear sweep establishes zeros.
  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i)   r_rdata <= '0;
    else if (re_i) r_rdata <= r_mem[raddr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/histogram_bellek.sv
// Histogram SRAM responder: clear sweep FSM, stall gating, write-first bypass, sticky error.
module histogram_bellek
  import histogram_bellek_pkg::*;
#(
  parameter int PIXEL_BIT = C_PIXEL_BIT,
  parameter int DATA_BIT  = C_DATA_BIT
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 stal_i,
  input  logic                 temizle_i,
  input  logic                 wr_en_i,
  input  logic [PIXEL_BIT-1:0] addr_w_i,
  input  logic [DATA_BIT-1:0]  data_in_i,
  input  logic                 rd_en_i,
  input  logic [PIXEL_BIT-1:0] addr_r_i,
  output logic [DATA_BIT-1:0]  data_out_o,
  output logic                 hazir_o,
  output logic                 hata_o
);

  durum_t               r_durum, w_durum_nxt;
  logic [PIXEL_BIT:0]   r_sayac, w_sayac_nxt;
  logic                 r_hata, w_hata_nxt;
  logic                 r_byp;
  logic [DATA_BIT-1:0]  r_byp_data;
  logic [DATA_BIT-1:0]  w_dizi_rdata;

  logic                 w_aktif, w_bosta, w_sil, w_yaz, w_oku, w_mem_we;
  logic [PIXEL_BIT-1:0] w_mem_waddr;
  logic [DATA_BIT-1:0]  w_mem_wdata;

  assign w_aktif = (stal_i == LOW);
  assign w_bosta = (r_durum == BOSTA);
  assign w_sil   = w_aktif && !w_bosta;
  assign w_yaz   = w_aktif && w_bosta && (wr_en_i == LOW);
  assign w_oku   = w_aktif && w_bosta && (rd_en_i == LOW);

  // The sweep owns the write port while clearing; controller writes are ignored then.
  assign w_mem_we    = w_yaz || w_sil;
  assign w_mem_waddr = w_sil ? r_sayac[PIXEL_BIT-1:0] : addr_w_i;
  assign w_mem_wdata = w_sil ? '0 : data_in_i;

  histogram_bellek_dizi #(
    .PIXEL_BIT (PIXEL_BIT),
    .DATA_BIT  (DATA_BIT)
  ) u_dizi (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .we_i    (w_mem_we),
    .waddr_i (w_mem_waddr),
    .wdata_i (w_mem_wdata),
    .re_i    (w_oku),
    .raddr_i (addr_r_i),
    .rdata_o (w_dizi_rdata)
  );

  // NOTE: every signal gets its default first so no path through this block infers a latch.
  always_comb begin
    w_durum_nxt = r_durum;
    w_sayac_nxt = r_sayac;
    w_hata_nxt  = r_hata;
    if (w_aktif) begin
      case (r_durum)
        TEMIZLE: begin
          if (wr_en_i == LOW || rd_en_i == LOW) w_hata_nxt = HIGH;
          if (r_sayac[PIXEL_BIT-1:0] == '1) begin
            w_durum_nxt = BOSTA;
            w_sayac_nxt = '0;
          end else begin
            w_sayac_nxt = r_sayac + 1'b1;
          end
        end
        BOSTA: begin
          if (temizle_i == HIGH) begin
            w_durum_nxt = TEMIZLE;
            w_sayac_nxt = '0;
          end
        end
        default: w_durum_nxt = TEMIZLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_durum <= TEMIZLE;
      r_sayac <= '0;
      r_hata  <= LOW;
    end else begin
      r_durum <= w_durum_nxt;
      r_sayac <= w_sayac_nxt;
      r_hata  <= w_hata_nxt;
    end
  end

  // Bypass data is captured alongside the array read so the output stays purely registered.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_byp      <= LOW;
      r_byp_data <= '0;
    end else if (w_oku) begin
      r_byp      <= w_yaz && (addr_w_i == addr_r_i);
      r_byp_data <= data_in_i;
    end
  end

  assign data_out_o = r_byp ? r_byp_data : w_dizi_rdata;
  assign hazir_o    = w_bosta;
  assign hata_o     = r_hata;

endmodule
